// File: rtl/osd_dp_packet_arbiter_pkg.sv
// Shared types for the debug-port packet arbiter: the DII flit carried on every
// input and on the arbitrated output.
package osd_dp_packet_arbiter_pkg;

   localparam int DII_DATA_W = 16;

   typedef struct packed {
      logic                  valid;
      logic                  last;
      logic [DII_DATA_W-1:0] data;
   } dii_flit;

endpackage

// File: rtl/osd_dp_packet_arbiter_if.sv
// Handshake bundle between the flit sources, the arbiter and the downstream DII port.
interface osd_dp_packet_arbiter_if #(
   parameter int CHANNELS = 2
);
   import osd_dp_packet_arbiter_pkg::*;

   dii_flit [CHANNELS-1:0] module_in;
   logic    [CHANNELS-1:0] module_in_ready;
   dii_flit                debug_out;
   logic                   debug_out_ready;
   logic                   stall;
   logic                   busy;

   modport master (
      output module_in, debug_out_ready, stall,
      input  module_in_ready, debug_out, busy
   );

   modport slave (
      input  module_in, debug_out_ready, stall,
      output module_in_ready, debug_out, busy
   );

endinterface

// File: rtl/osd_dp_arb_fifo.sv
// Small flit FIFO buffering the arbiter output; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module osd_dp_arb_fifo
   import osd_dp_packet_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst,
   input  dii_flit push_flit_i,
   input  logic    push_i,
   input  logic    pop_i,
   output dii_flit head_o,
   output logic    full_o,
   output logic    empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   dii_flit         mem_q [DEPTH];
   logic [AW-1:0]   wr_q;
   logic [AW-1:0]   rd_q;
   logic [CW-1:0]   count_q;
   logic            do_push;
   logic            do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = mem_q[rd_q];

   // Storage carries no reset; contents are don't-care while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_flit_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_q <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
         if (do_pop)  rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/osd_dp_packet_arbiter.sv
// Packet-atomic round-robin arbiter: a granted source keeps the output until its
// last flit is accepted, so packets from different sources never interleave.
//
//   state  | meaning
//   IDLE   | no owner; pick next valid source from rr_ptr_q upward unless stalled
//   LOCKED | grant_q owns the output until it transfers a flit with last set
module osd_dp_packet_arbiter
   import osd_dp_packet_arbiter_pkg::*;
#(
   parameter int CHANNELS   = 2,
   parameter int FIFO_DEPTH = 2
) (
   input logic                     clk,
   input logic                     rst,
   osd_dp_packet_arbiter_if.slave  bus
);

   localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic {IDLE, LOCKED} arb_state_e;

   arb_state_e             state_q;
   logic [GW-1:0]          grant_q;
   logic [GW-1:0]          rr_ptr_q;
   logic [CHANNELS-1:0]    req;
   logic [CHANNELS-1:0]    ready;
   logic                   sel_found;
   logic [GW-1:0]          sel_idx;
   logic [GW:0]            cand;
   dii_flit                in_flit;
   dii_flit                head;
   logic                   push;
   logic                   pop;
   logic                   full;
   logic                   empty;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_req
      assign req[i] = bus.module_in[i].valid;
   end

   // Walk downward so the candidate closest to rr_ptr_q is the last one written.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr_q} + (GW + 1)'(k);
         if (cand >= (GW + 1)'(CHANNELS)) cand = cand - (GW + 1)'(CHANNELS);
         if (req[cand[GW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[GW-1:0];
         end
      end
   end

   assign in_flit = bus.module_in[grant_q];
   assign push    = (state_q == LOCKED) && in_flit.valid && !full;
   assign pop     = !empty && bus.debug_out_ready;

   always_comb begin
      ready = '0;
      if (state_q == LOCKED && !full) ready[grant_q] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!bus.stall && sel_found) begin
                  grant_q <= sel_idx;
                  state_q <= LOCKED;
               end
            end
            LOCKED: begin
               if (push && in_flit.last) begin
                  rr_ptr_q <= (grant_q == GW'(CHANNELS - 1)) ? '0 : grant_q + 1'b1;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   osd_dp_arb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_flit_i (in_flit),
      .push_i      (push),
      .pop_i       (pop),
      .head_o      (head),
      .full_o      (full),
      .empty_o     (empty)
   );

   always_comb begin
      bus.debug_out       = head;
      bus.debug_out.valid = !empty && head.valid;
   end

   assign bus.module_in_ready = ready;
   assign bus.busy            = (state_q == LOCKED) || !empty;

endmodule

// File: tb/tb_osd_dp_packet_arbiter.sv
// Scoreboard bench: directed packets are queued per source, expected output flits
// are queued in order, and a monitor per DUT compares every output transfer.
module tb_osd_dp_packet_arbiter;
   import osd_dp_packet_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   osd_dp_packet_arbiter_if #(.CHANNELS(2)) ifa ();
   osd_dp_packet_arbiter_if #(.CHANNELS(3)) ifb ();

   osd_dp_packet_arbiter #(.CHANNELS(2), .FIFO_DEPTH(2)) dut_a (
      .clk (clk), .rst (rst), .bus (ifa.slave)
   );
   osd_dp_packet_arbiter #(.CHANNELS(3), .FIFO_DEPTH(2)) dut_b (
      .clk (clk), .rst (rst), .bus (ifb.slave)
   );

   int checks = 0;
   int errors = 0;
   logic [16:0] srcA [2][$];
   logic [16:0] srcB [3][$];
   logic [16:0] sbA [$];
   logic [16:0] sbB [$];
   int accA [2];
   int accB [3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Source drivers: a flit leaves its queue once valid&ready was seen mid-cycle.
   initial begin : drv_a
      logic [1:0] fire;
      ifa.module_in = '0;
      forever begin
         @(negedge clk);
         for (int c = 0; c < 2; c++) fire[c] = ifa.module_in[c].valid && ifa.module_in_ready[c];
         @(posedge clk);
         #1;
         for (int c = 0; c < 2; c++) begin
            if (rst) srcA[c].delete();
            else if (fire[c] && srcA[c].size() > 0) begin
               void'(srcA[c].pop_front());
               accA[c]++;
            end
            ifa.module_in[c] = (srcA[c].size() > 0) ? {1'b1, srcA[c][0]} : 18'd0;
         end
      end
   end

   initial begin : drv_b
      logic [2:0] fire;
      ifb.module_in = '0;
      forever begin
         @(negedge clk);
         for (int c = 0; c < 3; c++) fire[c] = ifb.module_in[c].valid && ifb.module_in_ready[c];
         @(posedge clk);
         #1;
         for (int c = 0; c < 3; c++) begin
            if (rst) srcB[c].delete();
            else if (fire[c] && srcB[c].size() > 0) begin
               void'(srcB[c].pop_front());
               accB[c]++;
            end
            ifb.module_in[c] = (srcB[c].size() > 0) ? {1'b1, srcB[c][0]} : 18'd0;
         end
      end
   end

   initial begin : mon_a
      logic [16:0] e;
      forever begin
         @(negedge clk);
         if (!rst && ifa.debug_out.valid && ifa.debug_out_ready) begin
            if (sbA.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL a_unexpected_flit: got 0x%0h expected none", ifa.debug_out.data);
            end else begin
               e = sbA.pop_front();
               chk("a_out_flit", 32'({ifa.debug_out.last, ifa.debug_out.data}), 32'(e));
            end
         end
      end
   end

   initial begin : mon_b
      logic [16:0] e;
      forever begin
         @(negedge clk);
         if (!rst && ifb.debug_out.valid && ifb.debug_out_ready) begin
            if (sbB.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL b_unexpected_flit: got 0x%0h expected none", ifb.debug_out.data);
            end else begin
               e = sbB.pop_front();
               chk("b_out_flit", 32'({ifb.debug_out.last, ifb.debug_out.data}), 32'(e));
            end
         end
      end
   end

   task automatic load_a(input int c, input logic [16:0] f);
      srcA[c].push_back(f);
   endtask

   task automatic drain_a(input string name, input int budget);
      int n = 0;
      while ((sbA.size() != 0 || ifa.busy || srcA[0].size() != 0 || srcA[1].size() != 0)
             && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(n < budget), 32'd1);
   endtask

   task automatic drain_b(input string name, input int budget);
      int n = 0;
      while ((sbB.size() != 0 || ifb.busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(n < budget), 32'd1);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      sbA.delete();
      sbB.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int b0, b1, n, viol;
      logic [16:0] f;
      ifa.debug_out_ready = 1'b1;
      ifa.stall           = 1'b0;
      ifb.debug_out_ready = 1'b1;
      ifb.stall           = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(ifa.module_in_ready), 32'd0);
      chk("rst_valid", 32'(ifa.debug_out.valid), 32'd0);
      chk("rst_busy", 32'(ifa.busy), 32'd0);
      chk("rst_b_ready", 32'(ifb.module_in_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single 3-flit packet on ch0, cycle 0 = first cycle valid is presented.
      load_a(0, {1'b0, 16'h0011}); sbA.push_back({1'b0, 16'h0011});
      load_a(0, {1'b0, 16'h0022}); sbA.push_back({1'b0, 16'h0022});
      load_a(0, {1'b1, 16'h0033}); sbA.push_back({1'b1, 16'h0033});
      @(posedge clk); #2;
      @(negedge clk);
      chk("ss_ready_c0", 32'(ifa.module_in_ready), 32'd0);
      @(negedge clk);
      chk("ss_ready_c1", 32'(ifa.module_in_ready), 32'd1);
      chk("ss_valid_c1", 32'(ifa.debug_out.valid), 32'd0);
      @(negedge clk);
      chk("ss_valid_c2", 32'(ifa.debug_out.valid), 32'd1);
      @(negedge clk);
      @(negedge clk);
      chk("ss_busy_c4", 32'(ifa.busy), 32'd1);
      chk("ss_ready_c4", 32'(ifa.module_in_ready), 32'd0);
      @(negedge clk);
      chk("ss_busy_c5", 32'(ifa.busy), 32'd0);
      chk("ss_valid_c5", 32'(ifa.debug_out.valid), 32'd0);
      drain_a("ss_drain", 20);

      // Contention from reset: ch0 packet first, then ch1, pointer wraps to 0.
      pulse_reset();
      @(negedge clk);
      load_a(0, {1'b0, 16'h0001}); load_a(0, {1'b1, 16'h0002});
      load_a(1, {1'b0, 16'h0081}); load_a(1, {1'b1, 16'h0082});
      sbA.push_back({1'b0, 16'h0001}); sbA.push_back({1'b1, 16'h0002});
      sbA.push_back({1'b0, 16'h0081}); sbA.push_back({1'b1, 16'h0082});
      drain_a("cont_drain", 50);
      chk("cont_rr_ptr", 32'(dut_a.rr_ptr_q), 32'd0);

      // Backpressure: only two flits fit before ready drops.
      @(posedge clk); #2;
      ifa.debug_out_ready = 1'b0;
      @(negedge clk);
      b0 = accA[0];
      for (int i = 1; i <= 4; i++) begin
         f = {(i == 4), 16'hA000 + 16'(i)};
         load_a(0, f);
         sbA.push_back(f);
      end
      repeat (10) @(negedge clk);
      chk("bp_accepted", 32'(accA[0] - b0), 32'd2);
      chk("bp_ready", 32'(ifa.module_in_ready), 32'd0);
      chk("bp_out_valid", 32'(ifa.debug_out.valid), 32'd1);
      @(posedge clk); #2;
      ifa.debug_out_ready = 1'b1;
      drain_a("bp_drain", 50);
      chk("bp_total", 32'(accA[0] - b0), 32'd4);

      // Stall mid-packet on ch1 while ch0 waits (rr_ptr is 1 here).
      @(negedge clk);
      b0 = accA[0];
      b1 = accA[1];
      load_a(1, {1'b0, 16'hB001}); load_a(1, {1'b0, 16'hB002}); load_a(1, {1'b1, 16'hB003});
      load_a(0, {1'b1, 16'hC000});
      sbA.push_back({1'b0, 16'hB001}); sbA.push_back({1'b0, 16'hB002});
      sbA.push_back({1'b1, 16'hB003}); sbA.push_back({1'b1, 16'hC000});
      n = 0;
      while (!ifa.module_in_ready[1] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("st_grant1", 32'(ifa.module_in_ready), 32'd2);
      ifa.stall = 1'b1;
      viol = 0;
      repeat (12) begin
         @(negedge clk);
         if (ifa.module_in_ready[0]) viol++;
      end
      chk("st_no_ch0_grant", 32'(viol), 32'd0);
      chk("st_ch1_done", 32'(accA[1] - b1), 32'd3);
      chk("st_ch0_wait", 32'(accA[0] - b0), 32'd0);
      ifa.stall = 1'b0;
      @(negedge clk);
      chk("st_grant0_after", 32'(ifa.module_in_ready), 32'd1);
      drain_a("st_drain", 50);

      // Reset after the first of three flits has been accepted.
      @(negedge clk);
      b0 = accA[0];
      load_a(0, {1'b0, 16'hD001}); load_a(0, {1'b0, 16'hD002}); load_a(0, {1'b1, 16'hD003});
      sbA.push_back({1'b0, 16'hD001});
      n = 0;
      do begin
         @(posedge clk); #2;
         n++;
      end while (accA[0] - b0 < 1 && n < 20);
      chk("rm_first_acc", 32'(accA[0] - b0), 32'd1);
      chk("rm_valid_before", 32'(ifa.debug_out.valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("rm_valid_rst", 32'(ifa.debug_out.valid), 32'd0);
      chk("rm_ready_rst", 32'(ifa.module_in_ready), 32'd0);
      chk("rm_busy_rst", 32'(ifa.busy), 32'd0);
      sbA.delete();
      sbB.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rm_idle_busy", 32'(ifa.busy), 32'd0);
      chk("rm_idle_ready", 32'(ifa.module_in_ready), 32'd0);
      chk("rm_idle_rr_ptr", 32'(dut_a.rr_ptr_q), 32'd0);

      // Fairness with three channels, two 1-flit packets each, all requesting.
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < 3; c++) begin
            f = {1'b1, 16'(c * 16 + k)};
            srcB[c].push_back(f);
            sbB.push_back(f);
         end
      end
      drain_b("fair_drain", 60);
      chk("fair_ch0_cnt", 32'(accB[0]), 32'd2);
      chk("fair_ch2_cnt", 32'(accB[2]), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
